reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Architectural register file for the pipelined CPU, instantiated inside the decode stage.
//  - 8 x 16-bit registers; r0 reads as zero and ignores writes.
//  - Two synchronous read ports feed the decode->execute pipeline register boundary.
//  - One write port is driven by writeback.
//  - A continuous debug/return tap exposes the return-value register.
// PARAMETERS
//  DATA_W   16  register width in bits
//  ADDR_W   3   register address width; the file holds 2**ADDR_W entries
//  RET_REG  3   index of the register mirrored on ret_val
// PORTS
//  clk         in   1       system clock; all state changes on its rising edge
//  rst_n       in   1       asynchronous active-low reset
//  raddr0      in   ADDR_W  read port 0 address (decode s_1)
//  rdata0      out  DATA_W  read port 0 data (decode d_1), registered
//  raddr1      in   ADDR_W  read port 1 address (decode s_2)
//  rdata1      out  DATA_W  read port 1 data (decode d_2), registered
//  wen         in   1       write enable
//  waddr       in   ADDR_W  write address (writeback target)
//  wdata       in   DATA_W  write data
//  ret_val     out  DATA_W  current contents of register RET_REG, combinational from state
// BEHAVIOUR
//  Reset
//  - rst_n=0 asynchronously clears all 8 registers, rdata0 and rdata1 to 0.
//  - Consequently ret_val=0 during reset.
//  - Reset has priority over any write or read in the same cycle.
//  Write
//  - On posedge clk with wen=1 and waddr!=0: reg[waddr] <= wdata.
//  - wen=0, or waddr=0: no state change.
//  Read
//  - On posedge clk: rdata0 <= value(raddr0) and rdata1 <= value(raddr1).
//  - Latency is 1 cycle, matching the other registered decode outputs.
//  - Reads happen every cycle; there is no read enable and no hold input.
//  value(a), evaluated in this priority order:
//  - a==0 -> 0.
//  - Else if wen && waddr==a -> wdata (write-first bypass: a same-cycle writeback is visible).
//  - Else -> reg[a].
//  - Both ports may address the same register, or the write target, simultaneously.
//    Each port resolves independently.
//  ret_val
//  - Equals reg[RET_REG] after the most recent edge.
//  - No bypass: a write to RET_REG appears on ret_val one edge later.
//  Widths
//  - No arithmetic; all data paths are exactly DATA_W.
//  - Address compares use the full ADDR_W bits.
//  Misc
//  - No X may reach rdata*/ret_val after reset.
//  - Register 0 storage may be optimised away but must always read 0.
// STRUCTURE
//  - Shared cpu package: REG_COUNT=8, ZERO_REG=3'd0, RET_REG default, DATA_W/ADDR_W constants.
//  - Single flat module: storage array, write logic, two identical bypassed read muxes.
//  - Optional sub-module rf_read_port (address -> bypassed, registered data), instantiated twice.
// TESTING
//  1 Reset: drop rst_n mid-cycle after writes
//    -> rdata0=rdata1=ret_val=0 immediately; all regs read 0 after release.
//  2 Write/read: wen=1 waddr=5 wdata=16'hBEEF; next cycle raddr0=5
//    -> rdata0=16'hBEEF one edge after the address is applied.
//  3 r0: wen=1 waddr=0 wdata=16'h1234; raddr0=raddr1=0
//    -> rdata0=rdata1=0 forever.
//  4 Bypass: same edge wen=1 waddr=2 wdata=16'h00A5, raddr1=2
//    -> rdata1=16'h00A5 after that edge.
//    Concurrently raddr0=4 holding 16'h7777 -> rdata0=16'h7777.
//  5 ret_val: write 16'hCAFE to r3
//    -> ret_val=16'hCAFE after the edge.
//    A write to r4 leaves ret_val unchanged.
//  6 Dual/all regs: fill r1..r7 with 16'h1111*i, sweep raddr0/raddr1 pairs incl. equal addresses
//    -> each port returns its register's value; wen=0 cycles change nothing.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared CPU constants for the architectural register file.
package reg_file_pkg;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int REG_COUNT = 2 ** ADDR_W;
    localparam int RET_REG   = 3;
    localparam logic [ADDR_W-1:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/reg_file_rf_read_port.sv
// One synchronous read port with write-first bypass and hardwired zero register.
// Latency: 1 cycle from address to registered data.
// Backpressure: none; the port samples every cycle.
module rf_read_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] value;

    // Zero register outranks the bypass so a write to r0 never leaks out.
    always_comb begin
        value = stored;
        if (raddr == '0)
            value = '0;
        else if (wen && (waddr == raddr))
            value = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else
            rdata <= value;
    end
endmodule

// File: rtl/reg_file.sv
// 8x16 architectural register file: two bypassed registered reads, one write, ret_val tap.
// Latency: reads 1 cycle; ret_val follows storage with no bypass.
// Backpressure: none; writes and reads take effect every cycle.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = reg_file_pkg::DATA_W,
    parameter int ADDR_W  = reg_file_pkg::ADDR_W,
    parameter int RET_REG = reg_file_pkg::RET_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ret_val
);
    localparam int ENTRIES = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [ENTRIES];

    // Entry 0 is cleared on reset and never written, so it stays constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                regs[i] <= '0;
        end else if (wen && (waddr != ADDR_W'(ZERO_REG))) begin
            regs[waddr] <= wdata;
        end
    end

    assign ret_val = regs[RET_REG];

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr  (raddr0),
        .stored (regs[raddr0]),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata0)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr  (raddr1),
        .stored (regs[raddr1]),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata1)
    );
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, r0, bypass, ret_val, full sweep, mid-cycle reset.
module tb_reg_file;
    logic        clk;
    logic        rst_n;
    logic [2:0]  raddr0;
    logic [15:0] rdata0;
    logic [2:0]  raddr1;
    logic [15:0] rdata1;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] ret_val;

    int tests;
    int fails;

    reg_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr0  (raddr0),
        .rdata0  (rdata0),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .ret_val (ret_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (rdata0 !== 16'h0) begin fails++; $display("FAIL reset_rdata0 got %h want 0000", rdata0); end
        tests++;
        if (rdata1 !== 16'h0) begin fails++; $display("FAIL reset_rdata1 got %h want 0000", rdata1); end
        tests++;
        if (ret_val !== 16'h0) begin fails++; $display("FAIL reset_ret_val got %h want 0000", ret_val); end
    endtask

    task automatic test_write_read();
        write_reg(3'd5, 16'hBEEF);
        raddr0 = 3'd5;
        tick();
        tests++;
        if (rdata0 !== 16'hBEEF) begin fails++; $display("FAIL write_read got %h want beef", rdata0); end
    endtask

    task automatic test_r0();
        wen = 1'b1; waddr = 3'd0; wdata = 16'h1234;
        raddr0 = 3'd0; raddr1 = 3'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (rdata0 !== 16'h0) begin fails++; $display("FAIL r0_port0 cyc %0d got %h want 0000", k, rdata0); end
            tests++;
            if (rdata1 !== 16'h0) begin fails++; $display("FAIL r0_port1 cyc %0d got %h want 0000", k, rdata1); end
        end
        wen = 1'b0;
        tick();
        tests++;
        if (rdata0 !== 16'h0) begin fails++; $display("FAIL r0_after_write got %h want 0000", rdata0); end
    endtask

    task automatic test_bypass();
        write_reg(3'd4, 16'h7777);
        wen = 1'b1; waddr = 3'd2; wdata = 16'h00A5;
        raddr1 = 3'd2; raddr0 = 3'd4;
        tick();
        wen = 1'b0;
        tests++;
        if (rdata1 !== 16'h00A5) begin fails++; $display("FAIL bypass_port1 got %h want 00a5", rdata1); end
        tests++;
        if (rdata0 !== 16'h7777) begin fails++; $display("FAIL bypass_port0 got %h want 7777", rdata0); end
        tick();
        tests++;
        if (rdata1 !== 16'h00A5) begin fails++; $display("FAIL bypass_stored got %h want 00a5", rdata1); end
    endtask

    task automatic test_ret_val();
        wen = 1'b1; waddr = 3'd3; wdata = 16'hCAFE;
        #1;
        tests++;
        if (ret_val !== 16'h0) begin fails++; $display("FAIL ret_no_bypass got %h want 0000", ret_val); end
        tick();
        wen = 1'b0;
        tests++;
        if (ret_val !== 16'hCAFE) begin fails++; $display("FAIL ret_after_write got %h want cafe", ret_val); end
        write_reg(3'd4, 16'h4444);
        tests++;
        if (ret_val !== 16'hCAFE) begin fails++; $display("FAIL ret_other_write got %h want cafe", ret_val); end
    endtask

    task automatic test_all_regs();
        logic [15:0] exp0, exp1;
        for (int i = 1; i < 8; i++) write_reg(3'(i), 16'(16'h1111 * i));
        tests++;
        if (ret_val !== 16'h3333) begin fails++; $display("FAIL sweep_ret_val got %h want 3333", ret_val); end
        for (int i = 0; i < 16; i++) begin
            raddr0 = 3'(i % 8);
            raddr1 = (i < 8) ? 3'(7 - i) : 3'(i % 8);
            exp0 = 16'(16'h1111 * int'(raddr0));
            exp1 = 16'(16'h1111 * int'(raddr1));
            tick();
            tests++;
            if (rdata0 !== exp0) begin fails++; $display("FAIL sweep_port0 addr %0d got %h want %h", raddr0, rdata0, exp0); end
            tests++;
            if (rdata1 !== exp1) begin fails++; $display("FAIL sweep_port1 addr %0d got %h want %h", raddr1, rdata1, exp1); end
        end
    endtask

    task automatic test_reset_mid();
        write_reg(3'd6, 16'hABCD);
        raddr0 = 3'd6; raddr1 = 3'd3;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rdata0 !== 16'h0) begin fails++; $display("FAIL midrst_rdata0 got %h want 0000", rdata0); end
        tests++;
        if (rdata1 !== 16'h0) begin fails++; $display("FAIL midrst_rdata1 got %h want 0000", rdata1); end
        tests++;
        if (ret_val !== 16'h0) begin fails++; $display("FAIL midrst_ret_val got %h want 0000", ret_val); end
        wen = 1'b1; waddr = 3'd6; wdata = 16'hFFFF;
        tick();
        tests++;
        if (rdata0 !== 16'h0) begin fails++; $display("FAIL midrst_priority got %h want 0000", rdata0); end
        wen = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddr0 = 3'(i); raddr1 = 3'(7 - i);
            tick();
            tests++;
            if (rdata0 !== 16'h0) begin fails++; $display("FAIL postrst_port0 addr %0d got %h want 0000", i, rdata0); end
            tests++;
            if (rdata1 !== 16'h0) begin fails++; $display("FAIL postrst_port1 addr %0d got %h want 0000", 7 - i, rdata1); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
        #23;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_write_read();
        test_r0();
        test_bypass();
        test_ret_val();
        test_all_regs();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
